// File: rtl/mult_arbiter_if.sv
// Requester/multiplier bus for mult_arbiter: the arbiter uses the slave modport, the
// environment (requesters plus the multiplier instance) uses master.
interface mult_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 16
);
    logic [NUM_REQ-1:0]       Req;
    logic [NUM_REQ*WIDTH-1:0] OpA;
    logic [NUM_REQ*WIDTH-1:0] OpB;
    logic [NUM_REQ-1:0]       Gnt;
    logic [NUM_REQ-1:0]       Ack;
    logic [2*WIDTH-1:0]       Result;
    logic                     Busy;
    logic                     Err;
    logic                     Mul_St;
    logic [WIDTH-1:0]         Mul_Multiplicando;
    logic [WIDTH-1:0]         Mul_Multiplicador;
    logic                     Mul_Done;
    logic                     Mul_Idle;
    logic [2*WIDTH-1:0]       Mul_Produto;

    modport slave (
        input  Req, OpA, OpB, Mul_Done, Mul_Idle, Mul_Produto,
        output Gnt, Ack, Result, Busy, Err, Mul_St, Mul_Multiplicando, Mul_Multiplicador
    );

    modport master (
        output Req, OpA, OpB, Mul_Done, Mul_Idle, Mul_Produto,
        input  Gnt, Ack, Result, Busy, Err, Mul_St, Mul_Multiplicando, Mul_Multiplicador
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports Err with Ack.
module mult_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic           Clk,
    input logic           Reset,
    mult_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mult_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [PtrW-1:0]      win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;

    logic                 sel_found;
    logic [PtrW-1:0]      sel_idx;
    int unsigned          sel_j;
    int unsigned          sel_base;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_j = (int'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && bus.Req[sel_j]) begin
                sel_found = 1'b1;
                sel_idx   = PtrW'(sel_j);
            end
        end
        sel_base = int'(sel_idx) * WIDTH;
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            err_q, err_d;
    logic            tmr_expired;

    assign tmr_expired = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        res_d   = res_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
`ifdef MULT_ARB_TIMEOUT_EN
        tmr_d   = tmr_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // The multiplier is not reset with us, so never start it while it is busy.
                if (sel_found && bus.Mul_Idle) begin
                    win_d          = sel_idx;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    op_a_d         = bus.OpA[sel_base +: WIDTH];
                    op_b_d         = bus.OpB[sel_base +: WIDTH];
                    state_d        = StStart;
                end
            end
            StStart: begin
`ifdef MULT_ARB_TIMEOUT_EN
                tmr_d = '0;
                err_d = 1'b0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (bus.Mul_Done) begin
                    res_d   = bus.Mul_Produto;
                    state_d = StResp;
`ifdef MULT_ARB_TIMEOUT_EN
                end else if (tmr_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tmr_d = tmr_q + 1'b1;
`endif
                end
            end
            StResp: begin
                ptr_d   = (win_q == PtrW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            res_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            res_q   <= res_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign bus.Err = (state_q == StResp) && err_q;
`else
    assign bus.Err = 1'b0;
`endif

    assign bus.Gnt               = gnt_q;
    assign bus.Ack               = (state_q == StResp) ? gnt_q : '0;
    assign bus.Result            = res_q;
    assign bus.Busy              = (state_q != StIdle);
    assign bus.Mul_St            = (state_q == StStart);
    assign bus.Mul_Multiplicando = op_a_q;
    assign bus.Mul_Multiplicador = op_b_q;
endmodule
